// File: rtl/pronoc_pkg.sv
// -----------------------------------------------------------------------------
// pronoc_pkg
//   Shared fat-tree router constants and the index-width helper used by the
//   up-port allocator and its round-robin pickers.
//   FT_K  : default number of up ports (and down ports) of a non-root router.
//   log2  : width of a binary index for n items, never less than 1.
// -----------------------------------------------------------------------------
package pronoc_pkg;

   localparam int FT_K = 2;

   // Bits needed to address n items; a single item still gets a 1-bit index.
   function automatic int log2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/fattree_rr_pick.sv
// -----------------------------------------------------------------------------
// fattree_rr_pick
//   Combinational round-robin picker: returns the first set request at or
//   after the pointer, wrapping around to index 0.
//   Ports:
//     req       [N-1:0]  request vector
//     ptr       [Nw-1:0] index with the highest priority this cycle
//     grant_oh  [N-1:0]  one-hot winner (all zero when nothing requests)
//     grant_idx [Nw-1:0] binary winner (0 when nothing requests)
//     any_valid          at least one request is set
// -----------------------------------------------------------------------------
module fattree_rr_pick
   import pronoc_pkg::*;
#(
   parameter int N  = 4,
   parameter int Nw = log2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [Nw-1:0] ptr,
   output logic [N-1:0]  grant_oh,
   output logic [Nw-1:0] grant_idx,
   output logic          any_valid
);

   // Two passes: the first covers [ptr, N-1], the second wraps to [0, ptr-1].
   // The second pass only fires when the first found nothing, so it naturally
   // yields the lowest set index below the pointer.
   always_comb begin
      // NOTE: every output gets a default before the search so no path leaves
      // it unassigned; a missing default here would infer a latch.
      grant_oh  = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any_valid && req[i] && (i >= int'(ptr))) begin
            grant_oh[i] = 1'b1;
            grant_idx   = Nw'(i);
            any_valid   = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!any_valid && req[i]) begin
            grant_oh[i] = 1'b1;
            grant_idx   = Nw'(i);
            any_valid   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fattree_upport_alloc.sv
// -----------------------------------------------------------------------------
// fattree_upport_alloc
//   Wormhole up-port allocator for a non-root fat-tree router. Inputs whose
//   head flit is routed upward compete for any free up port; at most one new
//   input/port pairing is made per cycle, picked round-robin on both sides.
//   Ownership persists until the input's tail flit has left.
//   Ports:
//     clk                    rising-edge clock
//     reset                  synchronous, active-high reset
//     req        [P-1:0]     input i has an upward head flit waiting
//     tail_sent  [P-1:0]     pulse: input i's tail flit left via its up port
//     up_ready   [K-1:0]     up port u has at least one downstream credit
//     own_valid  [P-1:0]     input i currently owns an up port
//     own_port   [P*Kw-1:0]  slice i: index of input i's owned up port (0 if none)
//     up_busy    [K-1:0]     up port u is owned by some input
//   All outputs come straight from registers.
// -----------------------------------------------------------------------------
module fattree_upport_alloc
   import pronoc_pkg::*;
#(
   parameter int K  = FT_K,
   parameter int P  = 2 * K,
   parameter int Kw = log2(K)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [P-1:0]    req,
   input  logic [P-1:0]    tail_sent,
   input  logic [K-1:0]    up_ready,
   output logic [P-1:0]    own_valid,
   output logic [P*Kw-1:0] own_port,
   output logic [K-1:0]    up_busy
);

   localparam int Pw = log2(P);

   // Owner table and busy bits: flat registers, one entry per input / port.
   logic [P-1:0]         own_valid_q;
   logic [P-1:0][Kw-1:0] own_port_q;
   logic [K-1:0]         up_busy_q;
   logic [Pw-1:0]        rr_in_q;
   logic [Kw-1:0]        rr_up_q;

   logic [P-1:0]  eligible;
   logic [K-1:0]  free_port;
   logic [P-1:0]  release_in;
   logic [K-1:0]  release_port;

   logic [P-1:0]  in_oh;
   logic [Pw-1:0] in_idx;
   logic          in_any;
   logic [K-1:0]  up_oh;
   logic [Kw-1:0] up_idx;
   logic          up_any;
   logic          alloc;

   // Eligibility is built only from registered state, so a port or input that
   // is released this cycle cannot be re-used until the next one.
   assign eligible   = req & ~own_valid_q;
   assign free_port  = up_ready & ~up_busy_q;
   assign release_in = tail_sent & own_valid_q;
   assign alloc      = in_any & up_any;

   // Map each releasing input to the up port it holds.
   always_comb begin
      release_port = '0;
      for (int i = 0; i < P; i++) begin
         for (int u = 0; u < K; u++) begin
            if (release_in[i] && (own_port_q[i] == Kw'(u))) begin
               release_port[u] = 1'b1;
            end
         end
      end
   end

   fattree_rr_pick #(
      .N  (P),
      .Nw (Pw)
   ) u_pick_in (
      .req       (eligible),
      .ptr       (rr_in_q),
      .grant_oh  (in_oh),
      .grant_idx (in_idx),
      .any_valid (in_any)
   );

   fattree_rr_pick #(
      .N  (K),
      .Nw (Kw)
   ) u_pick_up (
      .req       (free_port),
      .ptr       (rr_up_q),
      .grant_oh  (up_oh),
      .grant_idx (up_idx),
      .any_valid (up_any)
   );

   // A releasing input already owns a port, so it is never the new winner, and
   // a releasing port is still busy, so it is never the new port: release and
   // grant touch disjoint bits and can both be applied in the same cycle.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every update in
      // this block sees the pre-edge values, matching the hardware.
      if (reset) begin
         // NOTE: the owner table is cleared on reset (not just the valid bits)
         // so own_port reads 0 for every input without ownership.
         own_valid_q <= '0;
         own_port_q  <= '0;
         up_busy_q   <= '0;
         rr_in_q     <= '0;
         rr_up_q     <= '0;
      end else begin
         own_valid_q <= (own_valid_q & ~release_in) | (alloc ? in_oh : '0);
         up_busy_q   <= (up_busy_q & ~release_port) | (alloc ? up_oh : '0);
         for (int i = 0; i < P; i++) begin
            if (alloc && in_oh[i]) begin
               own_port_q[i] <= up_idx;
            end else if (release_in[i]) begin
               own_port_q[i] <= '0;
            end
         end
         if (alloc) begin
            rr_in_q <= (int'(in_idx) == P - 1) ? '0 : in_idx + 1'b1;
            rr_up_q <= (int'(up_idx) == K - 1) ? '0 : up_idx + 1'b1;
         end
      end
   end

   assign own_valid = own_valid_q;
   assign own_port  = own_port_q;
   assign up_busy   = up_busy_q;

endmodule

// File: tb/tb_fattree_upport_alloc.sv
// -----------------------------------------------------------------------------
// tb_fattree_upport_alloc
//   Directed vector table (K=2, P=4) with hand-computed expected state after
//   each clock edge, followed by a random run that checks the ownership
//   invariants and round-robin fairness bound every cycle.
// -----------------------------------------------------------------------------
module tb_fattree_upport_alloc;

   localparam int K  = 2;
   localparam int P  = 4;
   localparam int KW = 1;

   logic          clk;
   logic          reset;
   logic [P-1:0]  req;
   logic [P-1:0]  tail_sent;
   logic [K-1:0]  up_ready;
   logic [P-1:0]  own_valid;
   logic [P*KW-1:0] own_port;
   logic [K-1:0]  up_busy;

   int checks;
   int failures;

   fattree_upport_alloc #(
      .K  (K),
      .P  (P),
      .Kw (KW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .tail_sent (tail_sent),
      .up_ready  (up_ready),
      .own_valid (own_valid),
      .own_port  (own_port),
      .up_busy   (up_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_lt(input string name, input int act, input int limit);
      checks++;
      if (!(act < limit)) begin
         failures++;
         $display("FAIL %s: got %0d expected below %0d", name, act, limit);
      end
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] rq;
      logic [3:0] ts;
      logic [1:0] ur;
      logic [3:0] ov;
      logic [3:0] op;
      logic [1:0] ub;
      logic [1:0] rin;
      logic       rup;
   } vec_t;

   localparam int NVEC = 19;
   vec_t vec [NVEC];

   logic [P-1:0] prev_ov;
   logic [P-1:0] elig;
   logic [P-1:0] newg;
   logic [K-1:0] exp_busy;
   int           wait_cnt [P];
   int           max_wait;
   int           grants;
   int           pop_ov;
   int           pop_ub;
   logic         uniq_ok;
   logic         port_zero_ok;

   initial begin
      //          rst  req      ts       ur     ov       op       ub     rin    rup
      vec[0]  = '{1'b1, 4'b0000, 4'b0000, 2'b11, 4'b0000, 4'b0000, 2'b00, 2'd0, 1'b0}; // reset
      vec[1]  = '{1'b0, 4'b0101, 4'b0000, 2'b11, 4'b0001, 4'b0000, 2'b01, 2'd1, 1'b1}; // in0 -> port0
      vec[2]  = '{1'b0, 4'b0101, 4'b0000, 2'b11, 4'b0101, 4'b0100, 2'b11, 2'd3, 1'b0}; // in2 -> port1
      vec[3]  = '{1'b0, 4'b1101, 4'b0000, 2'b11, 4'b0101, 4'b0100, 2'b11, 2'd3, 1'b0}; // all busy
      vec[4]  = '{1'b0, 4'b1101, 4'b0001, 2'b11, 4'b0100, 4'b0100, 2'b10, 2'd3, 1'b0}; // tail0
      vec[5]  = '{1'b0, 4'b1101, 4'b0000, 2'b11, 4'b1100, 4'b0100, 2'b11, 2'd0, 1'b1}; // in3 -> port0
      vec[6]  = '{1'b0, 4'b0001, 4'b0010, 2'b11, 4'b1100, 4'b0100, 2'b11, 2'd0, 1'b1}; // stray tail1
      vec[7]  = '{1'b0, 4'b0010, 4'b0100, 2'b11, 4'b1000, 4'b0000, 2'b01, 2'd0, 1'b1}; // tail2, port1 not reused
      vec[8]  = '{1'b0, 4'b0010, 4'b0000, 2'b11, 4'b1010, 4'b0010, 2'b11, 2'd2, 1'b0}; // in1 -> port1
      vec[9]  = '{1'b1, 4'b1111, 4'b1111, 2'b11, 4'b0000, 4'b0000, 2'b00, 2'd0, 1'b0}; // reset mid-packet
      vec[10] = '{1'b0, 4'b0000, 4'b1111, 2'b11, 4'b0000, 4'b0000, 2'b00, 2'd0, 1'b0}; // tails ignored
      vec[11] = '{1'b0, 4'b1111, 4'b0000, 2'b10, 4'b0001, 4'b0001, 2'b10, 2'd1, 1'b0}; // only port1 ready
      vec[12] = '{1'b0, 4'b1111, 4'b0000, 2'b00, 4'b0001, 4'b0001, 2'b10, 2'd1, 1'b0}; // ready drop keeps owner
      vec[13] = '{1'b0, 4'b0010, 4'b0001, 2'b11, 4'b0010, 4'b0000, 2'b01, 2'd2, 1'b1}; // release + grant
      vec[14] = '{1'b0, 4'b0001, 4'b0000, 2'b11, 4'b0011, 4'b0001, 2'b11, 2'd1, 1'b0}; // wrap in0 -> port1
      vec[15] = '{1'b0, 4'b0000, 4'b0010, 2'b11, 4'b0001, 4'b0001, 2'b10, 2'd1, 1'b0}; // tail1
      vec[16] = '{1'b0, 4'b0100, 4'b0000, 2'b11, 4'b0101, 4'b0001, 2'b11, 2'd3, 1'b1}; // in2 -> port0
      vec[17] = '{1'b0, 4'b0100, 4'b0100, 2'b11, 4'b0001, 4'b0001, 2'b10, 2'd3, 1'b1}; // tail2, req held
      vec[18] = '{1'b0, 4'b0100, 4'b0000, 2'b11, 4'b0101, 4'b0001, 2'b11, 2'd3, 1'b1}; // in2 again -> port0

      checks   = 0;
      failures = 0;
      reset     = 1'b1;
      req       = '0;
      tail_sent = '0;
      up_ready  = '0;
      @(negedge clk);

      for (int v = 0; v < NVEC; v++) begin
         reset     = vec[v].rst;
         req       = vec[v].rq;
         tail_sent = vec[v].ts;
         up_ready  = vec[v].ur;
         @(negedge clk);
         check($sformatf("v%0d own_valid", v), 32'(own_valid), 32'(vec[v].ov));
         check($sformatf("v%0d own_port", v), 32'(own_port), 32'(vec[v].op));
         check($sformatf("v%0d up_busy", v), 32'(up_busy), 32'(vec[v].ub));
         check($sformatf("v%0d rr_in", v), 32'(dut.rr_in_q), 32'(vec[v].rin));
         check($sformatf("v%0d rr_up", v), 32'(dut.rr_up_q), 32'(vec[v].rup));
      end

      // Random run: requests are held until granted, so every waiting input
      // must win within P allocations.
      reset     = 1'b0;
      tail_sent = '0;
      prev_ov   = own_valid;
      grants    = 0;
      for (int i = 0; i < P; i++) wait_cnt[i] = 0;

      for (int c = 0; c < 10000; c++) begin
         req       = (req & ~own_valid) | (4'($urandom) & 4'($urandom));
         tail_sent = 4'($urandom) & 4'($urandom);
         up_ready  = ~(2'($urandom) & 2'($urandom));
         elig      = req & ~prev_ov;
         @(negedge clk);

         newg = own_valid & ~prev_ov;
         if (newg != '0) grants++;
         check($sformatf("rand%0d grants_per_cycle", c), 32'($countones(newg)) <= 32'd1 ? 32'd1 : 32'd0, 32'd1);

         uniq_ok      = 1'b1;
         port_zero_ok = 1'b1;
         exp_busy     = '0;
         for (int i = 0; i < P; i++) begin
            if (own_valid[i]) exp_busy[own_port[i]] = 1'b1;
            else if (own_port[i] != 1'b0) port_zero_ok = 1'b0;
            for (int j = i + 1; j < P; j++) begin
               if (own_valid[i] && own_valid[j] && (own_port[i] == own_port[j])) uniq_ok = 1'b0;
            end
         end
         pop_ov = $countones(own_valid);
         pop_ub = $countones(up_busy);
         check($sformatf("rand%0d unique_owner", c), 32'(uniq_ok), 32'd1);
         check($sformatf("rand%0d busy_matches_owners", c), 32'(up_busy), 32'(exp_busy));
         check($sformatf("rand%0d popcount", c), 32'(pop_ov), 32'(pop_ub));
         check($sformatf("rand%0d port_zero_when_idle", c), 32'(port_zero_ok), 32'd1);

         max_wait = 0;
         for (int i = 0; i < P; i++) begin
            if (elig[i]) begin
               if (newg[i]) wait_cnt[i] = 0;
               else if (newg != '0) wait_cnt[i]++;
            end else begin
               wait_cnt[i] = 0;
            end
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
         end
         check_lt($sformatf("rand%0d fairness_wait", c), max_wait, P);
         prev_ov = own_valid;
      end
      check_lt("rand total_grants_nonzero", 0, grants);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
